// File: rtl/debug_pkg.sv
// Shared constants for the register-file debug dumper.
// Optional checksum trailer is enabled by defining DUMP_CHECKSUM_EN.
package debug_pkg;

    localparam int unsigned NB_BYTE        = 8;
    localparam int unsigned NBITS_DEFAULT  = 32;
    localparam int unsigned BYTES_PER_WORD = NBITS_DEFAULT / NB_BYTE;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned BYTE_IDX_W = idx_width(BYTES_PER_WORD);

    // Dumper states (encodings kept as plain constants for legacy tooling).
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] WAIT = 3'd4;
    localparam logic [2:0] CSUM = 3'd5;
    localparam logic [2:0] FIN  = 3'd6;

endpackage

// File: rtl/debug_reg_dumper_if.sv
// Handshake/bus bundle between the dumper, the register file debug port
// and the UART TX path. Signal names match the legacy port list.
// The dumper uses the master modport; its environment uses slave.
interface debug_reg_dumper_if #(
    parameter int unsigned REGS    = 5,
    parameter int unsigned NBITS   = 32,
    parameter int unsigned NB_BYTE = 8
);

    logic               i_start;
    logic [NBITS-1:0]   i_RegData;
    logic               i_tx_done;
    logic [REGS-1:0]    o_RegDebug;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_done;

    modport master (
        input  i_start, i_RegData, i_tx_done,
        output o_RegDebug, o_tx_data, o_tx_start, o_busy, o_done
    );

    modport slave (
        output i_start, i_RegData, i_tx_done,
        input  o_RegDebug, o_tx_data, o_tx_start, o_busy, o_done
    );

endinterface

// File: rtl/debug_reg_dumper_word_byte_serializer.sv
// word_byte_serializer: sends one captured word LSB byte first over the
// UART start/done handshake and flags the acknowledge of its last byte.
// i_load_single sends only the low byte (used for the checksum trailer).
module word_byte_serializer #(
    parameter int unsigned NBITS   = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_load_single,
    input  logic [NBITS-1:0]   i_load_data,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_word_sent
);

    import debug_pkg::*;

    localparam int unsigned BPW = NBITS / NB_BYTE;
    localparam int unsigned IW  = idx_width(BPW);
    localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

    logic [2:0]         phase_q, phase_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               tx_start_q, tx_start_d;
    logic [NB_BYTE-1:0] tx_data_q, tx_data_d;

    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_word_sent = (phase_q == WAIT) && i_tx_done && (idx_q == LAST_IDX);

    // Byte sequencing: a load always wins, so a new word can start on the
    // same edge the previous word's last byte is acknowledged.
    always_comb begin
        phase_d    = phase_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        if (i_load) begin
            shift_d    = i_load_data;
            idx_d      = i_load_single ? LAST_IDX : '0;
            tx_start_d = 1'b1;
            phase_d    = SEND;
        end else begin
            case (phase_q)
                SEND: phase_d = WAIT;
                WAIT: begin
                    if (i_tx_done) begin
                        if (idx_q != LAST_IDX) begin
                            shift_d    = shift_q >> NB_BYTE;
                            idx_d      = idx_q + 1'b1;
                            tx_start_d = 1'b1;
                            phase_d    = SEND;
                        end else begin
                            phase_d = IDLE;
                        end
                    end
                end
                default: phase_d = IDLE;
            endcase
        end
        tx_data_d = (phase_d == SEND) ? shift_d[NB_BYTE-1:0] : tx_data_q;
    end

    // Serializer state registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: rtl/debug_reg_dumper.sv
// debug_reg_dumper: walks register addresses 0..CELDAS-1 on the register
// file debug port and streams every word to UART TX, LSB byte first.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after the dump.
module debug_reg_dumper #(
    parameter int unsigned REGS    = 5,
    parameter int unsigned NBITS   = 32,
    parameter int unsigned CELDAS  = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    debug_reg_dumper_if.master   bus
);

    import debug_pkg::*;

    localparam logic [REGS-1:0] LAST_ADDR = REGS'(CELDAS - 1);

    logic [2:0]         state_q, state_d;
    logic [REGS-1:0]    addr_q, addr_d;
    logic [REGS-1:0]    reg_debug_q, reg_debug_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               ser_load;
    logic               ser_single;
    logic [NBITS-1:0]   ser_data;
    logic               ser_tx_start;
    logic [NB_BYTE-1:0] ser_tx_data;
    logic               word_sent;

`ifdef DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q, csum_d;
`endif

    word_byte_serializer #(
        .NBITS   (NBITS),
        .NB_BYTE (NB_BYTE)
    ) u_ser (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load        (ser_load),
        .i_load_single (ser_single),
        .i_load_data   (ser_data),
        .i_tx_done     (bus.i_tx_done),
        .o_tx_start    (ser_tx_start),
        .o_tx_data     (ser_tx_data),
        .o_word_sent   (word_sent)
    );

    assign bus.o_RegDebug = reg_debug_q;
    assign bus.o_tx_data  = ser_tx_data;
    assign bus.o_tx_start = ser_tx_start;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;

    // Address sequencing FSM; WAIT covers the whole word while the
    // serializer runs its per-byte SEND/WAIT handshake.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ser_load   = 1'b0;
        ser_single = 1'b0;
        ser_data   = bus.i_RegData;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    addr_d  = '0;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = LOAD;
            LOAD: begin
                ser_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (word_sent) begin
                    if (addr_q < LAST_ADDR) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ADDR;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        ser_load   = 1'b1;
                        ser_single = 1'b1;
                        ser_data   = NBITS'(csum_q);
                        state_d    = CSUM;
`else
                        state_d    = FIN;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                if (word_sent) begin
                    state_d = FIN;
                end
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        reg_debug_d = reg_debug_q;
        if (state_d == IDLE) begin
            reg_debug_d = '0;
        end else if (state_d == ADDR) begin
            reg_debug_d = addr_d;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // FSM and registered output flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            reg_debug_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            reg_debug_q <= reg_debug_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Fold each data byte in as it is launched; the trailer byte itself
    // is launched outside WAIT and so is not folded.
    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE) begin
            csum_d = '0;
        end else if (state_q == WAIT && ser_tx_start) begin
            csum_d = csum_q ^ ser_tx_data;
        end
    end

    // Checksum register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule

// File: doc/debug_reg_dumper.md
Name: debug_reg_dumper

Overview:
- Read-side consumer of the MIPS register file's debug read port.
- On a start pulse from the debug unit, it walks register addresses 0..CELDAS-1 and presents each address on the debug address output.
- Each returned NBITS-wide word is captured and serialised, least-significant byte first, to the UART transmitter over a start/done byte handshake.
- Sits between the register file and the debug UART TX path.

Parameters:
- REGS, 5, register address width.
- NBITS, 32, register word width; must be a multiple of 8.
- CELDAS, 32, number of registers dumped.
- NB_BYTE, 8, TX byte width.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  dump request; sampled only in IDLE.
- i_RegData  in  NBITS  word from register file debug read port (combinational read).
- i_tx_done  in  1  UART TX finished current byte; single-cycle pulse.
- o_RegDebug  out  REGS  debug read address to register file.
- o_tx_data  out  NB_BYTE  byte to transmit.
- o_tx_start  out  1  one-cycle request to UART TX.
- o_busy  out  1  high from leaving IDLE until return to IDLE.
- o_done  out  1  one-cycle pulse after the last byte is acknowledged.

Behaviour:
- Reset: all outputs are 0; state = IDLE; internal address, byte index, shift register and checksum are cleared. Reset applies in any state and aborts a dump in progress; no further o_tx_start is issued.
- All outputs are registered.
- States and transitions:
  - IDLE: on i_start=1, go to ADDR with addr=0.
  - ADDR: o_RegDebug=addr; go to LOAD.
  - LOAD: capture i_RegData into the shift register; byte index=0; go to SEND.
  - SEND: o_tx_start=1 for exactly this cycle, o_tx_data = shift[7:0]; go to WAIT.
  - WAIT: hold o_tx_data; on i_tx_done, take the first matching branch:
    - If byte index < NBITS/8-1: shift right 8, increment index, go to SEND.
    - Else if addr < CELDAS-1: increment addr, go to ADDR.
    - Else go to FIN.
  - FIN: o_done=1 for one cycle; go to IDLE.
- Latency: o_tx_start is first high 3 cycles after the edge that samples i_start in IDLE (ADDR, LOAD, SEND).
- Minimum spacing between o_tx_start pulses: 2 cycles within a word, 4 cycles across a word boundary.
- A dump transmits CELDAS*NBITS/8 bytes; 128 with default parameters.
- o_RegDebug holds its value from ADDR until the next ADDR; it returns to 0 in IDLE.
- i_start while busy: ignored, with no queuing or restart.
- i_tx_done outside WAIT: ignored. i_tx_done held high: each WAIT lasts one cycle and no byte is skipped.
- The register file may be written during a dump; the dumper sends the value captured in LOAD.
- The address never wraps; the dump terminates after CELDAS-1.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - A NB_BYTE checksum register XORs every byte at its SEND.
  - After the last register's last byte is acknowledged, state CSUM asserts o_tx_start with o_tx_data = checksum, then waits for i_tx_done, then goes to FIN.
  - The checksum is cleared in IDLE.
  - Total bytes = CELDAS*NBITS/8 + 1.
- Undefined: no checksum logic; WAIT goes directly to FIN.

Decomposition:
- Package debug_pkg holds:
  - State enum / localparams: IDLE, ADDR, LOAD, SEND, WAIT, CSUM, FIN.
  - NB_BYTE.
  - BYTES_PER_WORD = NBITS/NB_BYTE.
  - Its log2 width for the byte index.
- One natural sub-module, word_byte_serializer: owns the shift register, byte index, and the SEND/WAIT handshake. It reports word_sent to the top FSM, which owns address sequencing and FIN/CSUM.

Test Plan:
- Reset: assert i_reset 3 cycles mid-idle and again at byte 50 of a dump. Required: all outputs 0 the cycle after; the next i_start yields first byte 0x00 from address 0.
- Full dump: register file at power-up values (reg i = i); TX stub pulses i_tx_done 2 cycles after each o_tx_start. Required: 128 bytes 00 00 00 00, 01 00 00 00, ..., 1F 00 00 00; o_done pulses exactly once; o_busy then drops.
- Latency and spacing: i_tx_done tied high. Required: first o_tx_start 3 cycles after i_start; pulses 2 cycles apart within a word and 4 apart across words; no byte lost.
- Busy lockout: i_start pulsed at bytes 5 and 127. Required: byte stream unchanged; a single o_done; no second dump.
- Word ordering: reg 7 written 0xDEADBEEF before start. Required: bytes 28..31 are EF BE AD DE.
- Checksum (DUMP_CHECKSUM_EN): reg 1 = 0x000000FF, others = index. Required: 129th byte = 0xFE; with all default values the 129th byte = 0x00.
